data_ram: RTL and testbench
===========================

# data_ram

Word-organised data memory that acts as the responder on the CPU's load/store port inside `sopc`. The CPU memory stage is the initiator. It presents one request per valid/ready handshake. The block applies a fixed, parameterised access latency, performs the read or byte-masked write, and returns exactly one single-cycle response per accepted request. Benches preload the internal `storage` array by hierarchical `$readmemh`.

## Interface
- `ADDRESS_WIDTH`, default 10: log2 of depth in 32-bit words; depth = 2^ADDRESS_WIDTH.
- `LATENCY`, default 2: wait cycles between accept and response; legal range 0..7.
- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `request_valid`  in  1  initiator presents a request.
- `request_ready`  out  1  block can accept this cycle.
- `request_write`  in  1  1 = store, 0 = load.
- `request_address`  in  32  byte address.
- `request_select`  in  4  byte enables; bit i enables byte lane i, data[8i+7:8i]; used on writes only.
- `request_data`  in  32  store data.
- `response_valid`  out  1  one-cycle pulse per accepted request.
- `response_data`  out  32  load data; 0 for stores and errors.
- `response_error`  out  1  qualifies `response_valid`; request was misaligned or out of range.

## Operation
- FSM states `IDLE`, `WAIT`, `RESPOND`. Reset forces `IDLE`, wait counter 0, captured request cleared.
- `request_ready` = (state == `IDLE`) && !`reset`. It is combinational from the state.
- Accept happens when `request_valid && request_ready` in `IDLE`. Address, write flag, select and data are captured.
  - `LATENCY` = 0: `IDLE` -> `RESPOND`.
  - Otherwise: `IDLE` -> `WAIT` with counter = `LATENCY`-1.
- `WAIT` decrements the counter each cycle and moves to `RESPOND` when the counter is 0.
- `RESPOND` drives `response_valid`=1 for one cycle, then returns to `IDLE`.
- Error condition, evaluated on the captured address: `address[1:0]` != 0, or any bit of `address[31:ADDRESS_WIDTH+2]` is set.
  - On error: no storage access, `response_error`=1, `response_data`=0.
- Word index = `address[ADDRESS_WIDTH+1:2]`.
- Read: `response_data` = full word; `request_select` is ignored.
- Write: the storage update happens on the edge that enters `RESPOND`. Only lanes with select=1 are updated. Select 0000 is a legal no-op with a normal response. `response_data` = 0.
- Storage is never cleared by reset. Unwritten words read as x in simulation.
- `request_*` inputs are ignored outside the accept cycle. No outstanding-request queue; at most one request is in flight.

## Timing
- Reset values: `request_ready`=0 while `reset`=1, then 1 on the first cycle after deassertion. `response_valid`=0, `response_data`=0, `response_error`=0.
- Accept at cycle N: `response_valid` is high in cycle N+1+`LATENCY`. `request_ready` is low in cycles N+1 .. N+1+`LATENCY` and high again in N+2+`LATENCY`.
- Maximum throughput: one request per `LATENCY`+2 cycles.
- Response outputs are registered and change only on clock edges. Outside the `response_valid` cycle, `response_data` and `response_error` are 0.
- Read-after-write to the same word: the load issued after the store's response returns the new data.
- Reset mid-operation (in `WAIT` or `RESPOND`) aborts the request:
  - a pending write not yet committed is discarded;
  - no response is emitted;
  - outputs go to reset values on that edge.
- `request_valid` held high across the response cycle is not accepted until `IDLE`. No request is dropped or double-accepted.

## Structure
- Shared `defines` package holds:
  - `WORD_WIDTH` (32) and `SELECT_WIDTH` (4);
  - state encodings `RAM_IDLE`, `RAM_WAIT`, `RAM_RESPOND`.
- Single module; the wait counter (3 bits) and byte-lane merge are inline. No sub-module is warranted.
- `storage` is declared as `reg [31:0] storage[0:2**ADDRESS_WIDTH-1]` so benches can address it hierarchically.

## Test plan
- Preload `storage[4]`=32'h01011101. Read address 32'h10 with `LATENCY`=2, accepted at cycle N -> `response_valid` at N+3, data 32'h01011101, error 0; `request_ready` low N+1..N+3.
- Write 32'hFFFF00FF to 32'h20 with select 4'b0011 over preload 32'h0000FF00, then read 32'h20 -> 32'h0000FF00 with lanes 0 and 1 replaced, i.e. 32'h000000FF.
- Misaligned read at 32'h13, and write at 32'h1000 with `ADDRESS_WIDTH`=10 -> each gives one response with error 1, data 0; the write leaves `storage[0]` unchanged.
- `request_valid` held high for 3 requests with `LATENCY`=0 -> accepts at cycles N, N+2, N+4, responses at N+1, N+3, N+5, never two in flight.
- Assert `reset` in the cycle after accepting a write to 32'h08 (`LATENCY`=2) -> no `response_valid`, `storage[2]` unchanged, `request_ready` 1 on the first cycle after `reset` deasserts.
- Write with select 4'b0000 -> normal response (error 0, data 0), word unchanged on readback.

Source files
------------

// File: rtl/defines.sv
// Shared definitions for the data memory: word geometry and FSM state codes.
package defines;

  localparam int WORD_WIDTH   = 32;
  localparam int SELECT_WIDTH = 4;

  // Responder FSM: idle and accepting, counting down the access latency,
  // or presenting the single-cycle response.
  typedef enum logic [1:0] {
    RAM_IDLE    = 2'd0,
    RAM_WAIT    = 2'd1,
    RAM_RESPOND = 2'd2
  } ram_state_t;

endpackage

// File: rtl/data_ram.sv
// Word-organised data memory serving the CPU load/store port.
//
// Handshake: a request transfers on a rising edge where request_valid and
// request_ready are both high; request_ready is high only in IDLE and never
// during reset. Every accepted request yields exactly one response_valid pulse
// LATENCY+1 cycles later, qualified by response_error; response_data and
// response_error are zero whenever response_valid is low.
module data_ram
  import defines::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int LATENCY       = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    request_valid,
  output logic                    request_ready,
  input  logic                    request_write,
  input  logic [31:0]             request_address,
  input  logic [SELECT_WIDTH-1:0] request_select,
  input  logic [WORD_WIDTH-1:0]   request_data,
  output logic                    response_valid,
  output logic [WORD_WIDTH-1:0]   response_data,
  output logic                    response_error
);

  localparam logic [2:0] LATENCY_LAST = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

  reg [31:0] storage [0:2**ADDRESS_WIDTH-1];

  ram_state_t                state;
  ram_state_t                state_next;
  logic [2:0]                count;
  logic [2:0]                count_next;

  logic                      cap_write;
  logic [31:0]               cap_address;
  logic [SELECT_WIDTH-1:0]   cap_select;
  logic [WORD_WIDTH-1:0]     cap_data;

  logic                      accept;
  logic                      commit;
  logic                      eff_write;
  logic [31:0]               eff_address;
  logic [SELECT_WIDTH-1:0]   eff_select;
  logic [WORD_WIDTH-1:0]     eff_data;
  logic                      eff_error;
  logic [ADDRESS_WIDTH-1:0]  word_index;

  assign request_ready = (state == RAM_IDLE) && !reset;
  assign accept        = request_valid && request_ready;

  // With zero latency the access happens on the accept edge itself, so the
  // live request is used in IDLE and the captured copy everywhere else.
  assign eff_write   = (state == RAM_IDLE) ? request_write   : cap_write;
  assign eff_address = (state == RAM_IDLE) ? request_address : cap_address;
  assign eff_select  = (state == RAM_IDLE) ? request_select  : cap_select;
  assign eff_data    = (state == RAM_IDLE) ? request_data    : cap_data;

  assign eff_error  = (eff_address[1:0] != 2'b00) ||
                      ((eff_address >> (ADDRESS_WIDTH + 2)) != 32'd0);
  assign word_index = eff_address[ADDRESS_WIDTH+1:2];

  // The access is performed on the edge that moves the FSM into RESPOND.
  assign commit = (state_next == RAM_RESPOND) && (state != RAM_RESPOND) && !reset;

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      RAM_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RAM_RESPOND;
          end else begin
            state_next = RAM_WAIT;
            count_next = LATENCY_LAST;
          end
        end
      end
      RAM_WAIT: begin
        if (count == 3'd0) begin
          state_next = RAM_RESPOND;
        end else begin
          count_next = count - 3'd1;
        end
      end
      RAM_RESPOND: state_next = RAM_IDLE;
      default:     state_next = RAM_IDLE;
    endcase
  end

  // State register, wait counter and request capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RAM_IDLE;
      count       <= 3'd0;
      cap_write   <= 1'b0;
      cap_address <= 32'd0;
      cap_select  <= '0;
      cap_data    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        cap_write   <= request_write;
        cap_address <= request_address;
        cap_select  <= request_select;
        cap_data    <= request_data;
      end
    end
  end

  // Registered response: one pulse, data only for error-free loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      response_valid <= 1'b0;
      response_data  <= '0;
      response_error <= 1'b0;
    end else if (commit) begin
      response_valid <= 1'b1;
      response_error <= eff_error;
      response_data  <= (eff_error || eff_write) ? '0 : storage[word_index];
    end else begin
      response_valid <= 1'b0;
      response_data  <= '0;
      response_error <= 1'b0;
    end
  end

  // Byte-lane merge into storage; storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (commit && eff_write && !eff_error) begin
      for (int lane = 0; lane < SELECT_WIDTH; lane++) begin
        if (eff_select[lane]) begin
          storage[word_index][8*lane +: 8] <= eff_data[8*lane +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: directed vector table, randomized traffic against a
// word-array reference model, mid-operation reset, zero-latency back-to-back.
module tb_data_ram;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // main instance, LATENCY = 2
  logic        request_valid = 1'b0;
  logic        request_ready;
  logic        request_write = 1'b0;
  logic [31:0] request_address = 32'd0;
  logic [3:0]  request_select = 4'd0;
  logic [31:0] request_data = 32'd0;
  logic        response_valid;
  logic [31:0] response_data;
  logic        response_error;

  // zero-latency instance
  logic        z_valid = 1'b0;
  logic        z_ready;
  logic        z_write = 1'b0;
  logic [31:0] z_addr = 32'd0;
  logic [3:0]  z_sel = 4'd0;
  logic [31:0] z_data = 32'd0;
  logic        z_resp_valid;
  logic [31:0] z_resp_data;
  logic        z_resp_error;

  data_ram #(.ADDRESS_WIDTH(10), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_address(request_address),
    .request_select(request_select), .request_data(request_data),
    .response_valid(response_valid), .response_data(response_data),
    .response_error(response_error)
  );

  data_ram #(.ADDRESS_WIDTH(10), .LATENCY(0)) dut_z (
    .clock(clock), .reset(reset),
    .request_valid(z_valid), .request_ready(z_ready),
    .request_write(z_write), .request_address(z_addr),
    .request_select(z_sel), .request_data(z_data),
    .response_valid(z_resp_valid), .response_data(z_resp_data),
    .response_error(z_resp_error)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:1023];

  function automatic logic [32:0] model_access(input logic w, input logic [31:0] a,
                                               input logic [3:0] s, input logic [31:0] d);
    logic [31:0] mask;
    int idx;
    if (a % 4 != 0 || a >= 32'd4096) return {1'b1, 32'd0};
    idx = int'(a / 4);
    if (w) begin
      mask = 32'd0;
      for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
      model_mem[idx] = (model_mem[idx] & ~mask) | (d & mask);
      return {1'b0, 32'd0};
    end
    return {1'b0, model_mem[idx]};
  endfunction

  // ---------------- driver ----------------
  // Issues one request on the main instance and checks the full response
  // timing against the front of exp_q.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input string name);
    int k;
    int waitn;
    logic got;
    logic [32:0] exp;
    @(negedge clock);
    request_valid = 1'b1; request_write = w; request_address = a;
    request_select = s; request_data = d;
    waitn = 0;
    while (!request_ready && waitn < 20) begin
      @(negedge clock);
      waitn++;
    end
    if (!request_ready) begin
      checks++; failures++;
      $display("FAIL %s_accept actual=no_ready required=ready", name);
    end
    @(negedge clock);
    // request inputs must be ignored after the accept cycle
    request_valid = 1'b0; request_write = 1'($urandom);
    request_address = $urandom; request_select = 4'($urandom); request_data = $urandom;
    k = 1; got = 1'b0;
    while (k <= LAT + 4) begin
      if (response_valid) begin
        got = 1'b1;
        break;
      end
      chk({name, "_busy_ready"}, 64'(request_ready), 64'd0);
      chk({name, "_idle_resp"}, {31'd0, response_error, response_data}, 64'd0);
      @(negedge clock);
      k++;
    end
    exp = exp_q.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_response actual=none required=pulse", name);
    end else begin
      chk({name, "_latency"}, 64'(k), 64'(LAT + 1));
      chk({name, "_resp_ready"}, 64'(request_ready), 64'd0);
      chk({name, "_resp"}, {31'd0, response_error, response_data}, {31'd0, exp});
      @(negedge clock);
      chk({name, "_after_valid"}, 64'(response_valid), 64'd0);
      chk({name, "_after_ready"}, 64'(request_ready), 64'd1);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int acc_t [3];
    int rsp_t [3];
    int nacc;
    int nrsp;
    logic [31:0] saved;
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 32'h10,       4'hF, 32'h01011101, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,       4'h0, 32'h0,        1'b0, 32'h01011101};
    vecs[2]  = '{1'b1, 32'h20,       4'hF, 32'h0000FF00, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h20,       4'h3, 32'hFFFF00FF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h20,       4'hA, 32'h0,        1'b0, 32'h000000FF};
    vecs[5]  = '{1'b1, 32'h00,       4'hF, 32'h12345678, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h13,       4'hF, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h1000,     4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h00,       4'h0, 32'h0,        1'b0, 32'h12345678};
    vecs[9]  = '{1'b1, 32'h20,       4'h0, 32'hAAAAAAAA, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h20,       4'h0, 32'h0,        1'b0, 32'h000000FF};
    vecs[11] = '{1'b0, 32'h80000010, 4'h0, 32'h0,        1'b1, 32'h0};

    // reset state
    repeat (3) @(negedge clock);
    chk("reset_ready", 64'(request_ready), 64'd0);
    chk("reset_resp", {31'd0, response_valid, response_error, response_data}, 64'd0);
    chk("reset_ready_z", 64'(z_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(request_ready), 64'd1);

    // directed table
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].e_err, vecs[i].e_data});
      void'(model_access(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d));
      do_req(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, $sformatf("vec%0d", i));
    end
    chk("err_write_no_alias", 64'(dut.storage[0]), 64'h12345678);

    // initialize words 0..15 so random loads have known contents
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4); d = $urandom;
      exp_q.push_back(model_access(1'b1, a, 4'hF, d));
      do_req(1'b1, a, 4'hF, d, "init");
    end

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 7))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = a | (32'h1000 << $urandom_range(0, 19));
        default: ;
      endcase
      s = 4'($urandom);
      d = $urandom;
      exp_q.push_back(model_access(w, a, s, d));
      do_req(w, a, s, d, "rand");
    end

    // reset in the cycle after accepting a write: the write must be dropped
    saved = model_mem[2];
    @(negedge clock);
    request_valid = 1'b1; request_write = 1'b1; request_address = 32'h08;
    request_select = 4'hF; request_data = ~saved;
    chk("rst_accept_ready", 64'(request_ready), 64'd1);
    @(negedge clock);
    request_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_no_valid", 64'(response_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", 64'(request_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("rst_no_response", 64'(response_valid), 64'd0);
    end
    chk("rst_storage2", 64'(dut.storage[2]), 64'(saved));

    // zero latency, request_valid held high for three requests
    nacc = 0; nrsp = 0;
    @(negedge clock);
    z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h40; z_sel = 4'hF; z_data = $urandom;
    for (int t = 0; t < 10; t++) begin
      if (nacc == 3) z_valid = 1'b0;
      if (z_valid && z_ready) begin
        acc_t[nacc] = t;
        nacc++;
      end
      if (z_resp_valid) begin
        if (nrsp < 3) rsp_t[nrsp] = t;
        nrsp++;
        chk("z_resp", {31'd0, z_resp_error, z_resp_data}, 64'd0);
      end
      @(negedge clock);
    end
    chk("z_accepts", 64'(nacc), 64'd3);
    chk("z_responses", 64'(nrsp), 64'd3);
    if (nacc == 3 && nrsp == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("z_accept%0d_cycle", i), 64'(acc_t[i]), 64'(2 * i));
        chk($sformatf("z_resp%0d_cycle", i), 64'(rsp_t[i]), 64'(2 * i + 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time guard
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
